// File: rtl/id_exe_reg_pkg.sv
// Shared pipeline definitions: forward-select encodings, load encoding and the ID/EXE register layout.
package id_exe_reg_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EXE     = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_sel_e;

    localparam logic [2:0] MEMREAD_NONE = 3'b000;

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_write;
        logic [2:0]    mem_read;
        logic [3:0]    alu_op;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
    } exe_regs_t;

    function automatic logic is_load(input logic [2:0] mem_read);
        return mem_read != MEMREAD_NONE;
    endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// ID/EXE boundary bundle: ID-side fields and forward sources in, EXE-side registered fields out.
interface id_exe_reg_if;
    import id_exe_reg_pkg::*;

    logic          flush;
    logic          hold;
    logic [1:0]    hd_rs;
    logic [1:0]    hd_rt;
    logic [DW-1:0] rs_data_id;
    logic [DW-1:0] rt_data_id;
    logic [DW-1:0] imm_id;
    logic [DW-1:0] pc_id;
    logic [DW-1:0] alu_result_exe;
    logic [DW-1:0] alu_result_mem;
    logic [DW-1:0] mem_rdata_mem;
    logic [RW-1:0] rs_id;
    logic [RW-1:0] rt_id;
    logic [RW-1:0] rd_id;
    logic          valid_id;
    logic          RegWrite_id;
    logic          MemWrite_id;
    logic [2:0]    MemRead_id;
    logic [3:0]    ALUop_id;

    logic [DW-1:0] rs_val_exe;
    logic [DW-1:0] rt_val_exe;
    logic [DW-1:0] imm_exe;
    logic [DW-1:0] pc_exe;
    logic [RW-1:0] rs_exe;
    logic [RW-1:0] rt_exe;
    logic [RW-1:0] rd_exe;
    logic          valid_exe;
    logic          RegWrite_exe;
    logic          MemWrite_exe;
    logic [2:0]    MemRead_exe;
    logic [3:0]    ALUop_exe;
    logic          load_use_stall;
    logic [15:0]   bubble_cnt;

    modport master (
        output flush, hold, hd_rs, hd_rt, rs_data_id, rt_data_id, imm_id, pc_id,
               alu_result_exe, alu_result_mem, mem_rdata_mem, rs_id, rt_id, rd_id,
               valid_id, RegWrite_id, MemWrite_id, MemRead_id, ALUop_id,
        input  rs_val_exe, rt_val_exe, imm_exe, pc_exe, rs_exe, rt_exe, rd_exe,
               valid_exe, RegWrite_exe, MemWrite_exe, MemRead_exe, ALUop_exe,
               load_use_stall, bubble_cnt
    );

    modport slave (
        input  flush, hold, hd_rs, hd_rt, rs_data_id, rt_data_id, imm_id, pc_id,
               alu_result_exe, alu_result_mem, mem_rdata_mem, rs_id, rt_id, rd_id,
               valid_id, RegWrite_id, MemWrite_id, MemRead_id, ALUop_id,
        output rs_val_exe, rt_val_exe, imm_exe, pc_exe, rs_exe, rt_exe, rd_exe,
               valid_exe, RegWrite_exe, MemWrite_exe, MemRead_exe, ALUop_exe,
               load_use_stall, bubble_cnt
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding 4:1 mux: regfile, EXE ALU, MEM ALU or MEM load data.
// Purely combinational; sources are the same-cycle values.
module fwd_mux
    import id_exe_reg_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_rf,
    input  logic [DW-1:0] i_exe,
    input  logic [DW-1:0] i_mem_alu,
    input  logic [DW-1:0] i_mem_ld,
    output logic [DW-1:0] o_dat
);

    always_comb begin
        o_dat = i_rf;
        case (fwd_sel_e'(i_sel))
            FWD_RF:      o_dat = i_rf;
            FWD_EXE:     o_dat = i_exe;
            FWD_MEM_ALU: o_dat = i_mem_alu;
            FWD_MEM_LD:  o_dat = i_mem_ld;
        endcase
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with operand forwarding, load-use bubble insertion and a bubble counter.
// One-cycle latency; hold freezes everything, flush and load-use stalls load a bubble.
module id_exe_reg
    import id_exe_reg_pkg::*;
(
    input logic         clk,
    input logic         rst,
    id_exe_reg_if.slave bus
);

    logic [DW-1:0] w_rs_fwd;
    logic [DW-1:0] w_rt_fwd;
    logic          w_rd_hit;
    logic          w_stall;
    exe_regs_t     w_capture;
    exe_regs_t     r_exe;
    logic [15:0]   r_bubble_cnt;

    fwd_mux #(.DW(DW)) u_rs_mux (
        .i_sel     (bus.hd_rs),
        .i_rf      (bus.rs_data_id),
        .i_exe     (bus.alu_result_exe),
        .i_mem_alu (bus.alu_result_mem),
        .i_mem_ld  (bus.mem_rdata_mem),
        .o_dat     (w_rs_fwd)
    );

    fwd_mux #(.DW(DW)) u_rt_mux (
        .i_sel     (bus.hd_rt),
        .i_rf      (bus.rt_data_id),
        .i_exe     (bus.alu_result_exe),
        .i_mem_alu (bus.alu_result_mem),
        .i_mem_ld  (bus.mem_rdata_mem),
        .o_dat     (w_rt_fwd)
    );

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_rd_hit = (r_exe.rd == bus.rs_id) || (r_exe.rd == bus.rt_id);
    assign w_stall  = bus.valid_id & r_exe.valid & r_exe.reg_write & is_load(r_exe.mem_read)
                    & (r_exe.rd != '0) & w_rd_hit;

    always_comb begin
        w_capture = '0;
        if (bus.valid_id) begin
            w_capture.valid     = 1'b1;
            w_capture.reg_write = bus.RegWrite_id;
            w_capture.mem_write = bus.MemWrite_id;
            w_capture.mem_read  = bus.MemRead_id;
            w_capture.alu_op    = bus.ALUop_id;
            w_capture.rs        = bus.rs_id;
            w_capture.rt        = bus.rt_id;
            w_capture.rd        = bus.rd_id;
            w_capture.rs_val    = w_rs_fwd;
            w_capture.rt_val    = w_rt_fwd;
            w_capture.imm       = bus.imm_id;
            w_capture.pc        = bus.pc_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe        <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.flush) begin
            r_exe <= '0;
        end else if (bus.hold) begin
            r_exe <= r_exe;
        end else if (w_stall) begin
            r_exe <= '0;
            if (r_bubble_cnt != 16'hFFFF) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end else begin
            r_exe <= w_capture;
        end
    end

    assign bus.valid_exe      = r_exe.valid;
    assign bus.RegWrite_exe   = r_exe.reg_write;
    assign bus.MemWrite_exe   = r_exe.mem_write;
    assign bus.MemRead_exe    = r_exe.mem_read;
    assign bus.ALUop_exe      = r_exe.alu_op;
    assign bus.rs_exe         = r_exe.rs;
    assign bus.rt_exe         = r_exe.rt;
    assign bus.rd_exe         = r_exe.rd;
    assign bus.rs_val_exe     = r_exe.rs_val;
    assign bus.rt_val_exe     = r_exe.rt_val;
    assign bus.imm_exe        = r_exe.imm;
    assign bus.pc_exe         = r_exe.pc;
    assign bus.load_use_stall = w_stall;
    assign bus.bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: a reference model predicts each edge's outputs, compared one cycle later.
module tb_id_exe_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_exe_reg_if bus();

    id_exe_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic        regw;
        logic        memw;
        logic [2:0]  memrd;
        logic [3:0]  aluop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [15:0] cnt;
    } obs_t;

    obs_t m;
    obs_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_pick(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'b00:   return rf;
            2'b01:   return bus.alu_result_exe;
            2'b10:   return bus.alu_result_mem;
            default: return bus.mem_rdata_mem;
        endcase
    endfunction

    function automatic logic model_stall(input obs_t cur);
        return bus.valid_id && cur.valid && cur.regw && (cur.memrd != 3'b000) && (cur.rd != 5'd0)
            && ((cur.rd == bus.rs_id) || (cur.rd == bus.rt_id));
    endfunction

    function automatic obs_t model_next(input obs_t cur);
        obs_t n;
        n = cur;
        if (rst) begin
            n = '0;
        end else if (bus.flush) begin
            n = '0;
            n.cnt = cur.cnt;
        end else if (bus.hold) begin
            n = cur;
        end else if (model_stall(cur)) begin
            n = '0;
            n.cnt = (cur.cnt == 16'hFFFF) ? 16'hFFFF : cur.cnt + 16'd1;
        end else begin
            n = '0;
            n.cnt = cur.cnt;
            if (bus.valid_id) begin
                n.valid = 1'b1;
                n.regw  = bus.RegWrite_id;
                n.memw  = bus.MemWrite_id;
                n.memrd = bus.MemRead_id;
                n.aluop = bus.ALUop_id;
                n.rs    = bus.rs_id;
                n.rt    = bus.rt_id;
                n.rd    = bus.rd_id;
                n.rsv   = fwd_pick(bus.hd_rs, bus.rs_data_id);
                n.rtv   = fwd_pick(bus.hd_rt, bus.rt_data_id);
                n.imm   = bus.imm_id;
                n.pc    = bus.pc_id;
            end
        end
        return n;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.valid = bus.valid_exe;
        s.regw  = bus.RegWrite_exe;
        s.memw  = bus.MemWrite_exe;
        s.memrd = bus.MemRead_exe;
        s.aluop = bus.ALUop_exe;
        s.rs    = bus.rs_exe;
        s.rt    = bus.rt_exe;
        s.rd    = bus.rd_exe;
        s.rsv   = bus.rs_val_exe;
        s.rtv   = bus.rt_val_exe;
        s.imm   = bus.imm_exe;
        s.pc    = bus.pc_exe;
        s.cnt   = bus.bubble_cnt;
        return s;
    endfunction

    // One clock: check the live stall, predict, clock, then compare against the popped prediction.
    task automatic step();
        obs_t e;
        obs_t g;
        #1;
        chk("stall", bus.load_use_stall, model_stall(m));
        sb.push_back(model_next(m));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        g = sample();
        chk("valid", g.valid, e.valid);
        chk("ctrl", {g.regw, g.memw, g.memrd, g.aluop}, {e.regw, e.memw, e.memrd, e.aluop});
        chk("idx", {g.rs, g.rt, g.rd}, {e.rs, e.rt, e.rd});
        chk("rs_val", g.rsv, e.rsv);
        chk("rt_val", g.rtv, e.rtv);
        chk("imm", g.imm, e.imm);
        chk("pc", g.pc, e.pc);
        chk("bubble_cnt", g.cnt, e.cnt);
        m = e;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic regw, input logic [2:0] memrd, input logic [3:0] aluop);
        bus.valid_id       = v;
        bus.rs_id          = rs;
        bus.rt_id          = rt;
        bus.rd_id          = rd;
        bus.RegWrite_id    = regw;
        bus.MemWrite_id    = 1'($urandom_range(0, 1));
        bus.MemRead_id     = memrd;
        bus.ALUop_id       = aluop;
        bus.hd_rs          = 2'b00;
        bus.hd_rt          = 2'b00;
        bus.rs_data_id     = $urandom;
        bus.rt_data_id     = $urandom;
        bus.imm_id         = $urandom;
        bus.pc_id          = $urandom;
        bus.alu_result_exe = $urandom;
        bus.alu_result_mem = $urandom;
        bus.mem_rdata_mem  = $urandom;
    endtask

    initial begin
        rst      = 1'b1;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'b010, 4'h3);
        @(posedge clk);
        #1;
        m = '0;

        // Reset dominates valid ID input
        step();
        chk("rst_valid", bus.valid_exe, 1'b0);
        chk("rst_cnt", bus.bubble_cnt, 16'h0000);
        chk("rst_stall", bus.load_use_stall, 1'b0);
        rst = 1'b0;

        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 4'h2);
        bus.hd_rs = 2'b01;
        bus.alu_result_exe = 32'h0000_1234;
        step();
        chk("fwd_exe_rs", bus.rs_val_exe, 32'h0000_1234);
        chk("fwd_exe_valid", bus.valid_exe, 1'b1);

        for (int s = 0; s < 16; s++) begin
            set_id(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15)));
            bus.hd_rs = 2'(s);
            bus.hd_rt = 2'(s >> 2);
            step();
        end

        // Load-use on rs
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 3'b010, 4'h0);
        step();
        set_id(1'b1, 5'd5, 5'd7, 5'd9, 1'b1, 3'b000, 4'h1);
        #1;
        chk("lu_stall_hi", bus.load_use_stall, 1'b1);
        step();
        chk("lu_bubble_valid", bus.valid_exe, 1'b0);
        chk("lu_bubble_rd", bus.rd_exe, 5'd0);
        chk("lu_cnt", bus.bubble_cnt, 16'd1);
        chk("lu_stall_lo", bus.load_use_stall, 1'b0);
        step();
        chk("lu_dep_rs", bus.rs_exe, 5'd5);

        // Load into r0 never stalls
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 3'b001, 4'h0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 3'b000, 4'h0);
        #1;
        chk("rd0_nostall", bus.load_use_stall, 1'b0);
        step();

        // Flush wins over hold and does not count
        set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 3'b100, 4'h0);
        step();
        set_id(1'b1, 5'd3, 5'd6, 5'd7, 1'b1, 3'b000, 4'h4);
        bus.flush = 1'b1;
        bus.hold  = 1'b1;
        #1;
        chk("fh_stall_hi", bus.load_use_stall, 1'b1);
        step();
        chk("fh_valid", bus.valid_exe, 1'b0);
        chk("fh_cnt", bus.bubble_cnt, 16'd1);
        bus.flush = 1'b0;
        bus.hold  = 1'b0;

        // Hold freezes outputs while stall tracks ID
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 3'b010, 4'h5);
        step();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, (i == 1) ? 5'd8 : 5'd9, 5'd10, 5'd11, 1'b1, 3'b000, 4'($urandom_range(0, 15)));
            #1;
            chk("hold_stall", bus.load_use_stall, (i == 1));
            step();
            chk("hold_rd", bus.rd_exe, 5'd8);
            chk("hold_cnt", bus.bubble_cnt, 16'd1);
        end
        bus.hold = 1'b0;

        for (int i = 0; i < 300; i++) begin
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.hold  = ($urandom_range(0, 7) == 0);
            set_id(($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000, 4'($urandom_range(0, 15)));
            bus.hd_rs = 2'($urandom_range(0, 3));
            bus.hd_rt = 2'($urandom_range(0, 3));
            step();
        end
        bus.flush = 1'b0;
        bus.hold  = 1'b0;

        // Saturation: preload counter near the top
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 4'h0);
        step();
        force dut.r_bubble_cnt = 16'hFFFE;
        #1;
        release dut.r_bubble_cnt;
        m.cnt = 16'hFFFE;
        chk("sat_preload", bus.bubble_cnt, 16'hFFFE);
        for (int k = 0; k < 2; k++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 3'b010, 4'h0);
            step();
            set_id(1'b1, 5'd12, 5'd3, 5'd20, 1'b1, 3'b000, 4'h0);
            step();
            chk("sat_cnt", bus.bubble_cnt, 16'hFFFF);
        end

        // Reset in the middle of a stall
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 3'b011, 4'h0);
            step();
            set_id(1'b1, 5'd3, 5'd14, 5'd21, 1'b1, 3'b000, 4'h0);
            step();
        end
        set_id(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 3'b010, 4'h0);
        step();
        set_id(1'b1, 5'd13, 5'd4, 5'd22, 1'b1, 3'b000, 4'h0);
        #1;
        chk("pre_rst_stall", bus.load_use_stall, 1'b1);
        chk("pre_rst_cnt", bus.bubble_cnt, 16'd7);
        rst = 1'b1;
        step();
        chk("rst_mid_valid", bus.valid_exe, 1'b0);
        chk("rst_mid_rd", bus.rd_exe, 5'd0);
        chk("rst_mid_memrd", bus.MemRead_exe, 3'b000);
        chk("rst_mid_cnt", bus.bubble_cnt, 16'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", bus.load_use_stall, 1'b0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
